generador_senales_bus: RTL and testbench

//  Downstream consumer of the 4-bit bus-timing phase index (fase, 0..14) produced by the free-running

---
 rtl/bus_tiempos_pkg.sv | 32 +++
 rtl/generador_senales_bus_decodificador_fase.sv | 48 ++++
 rtl/generador_senales_bus.sv | 123 ++++++++++++
 tb/tb_generador_senales_bus.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_tiempos_pkg.sv
// Shared definitions for the bus-timing consumers.
//   estado_t      sequencer state encoding
//   FASE_*        named points of the 15-phase bus frame
//   ctrl_bus_t    control strobes driven to the pads, plus output enable
//   BUS_INACTIVO  idle pattern of the control strobes
package bus_tiempos_pkg;

    typedef enum logic [1:0] {
        REPOSO       = 2'd0,
        ESPERA_TRAMA = 2'd1,
        TRAMA        = 2'd2,
        FIN          = 2'd3
    } estado_t;

    localparam logic [3:0] FASE_DIR_INI = 4'd0;
    localparam logic [3:0] FASE_DIR_STB = 4'd1;
    localparam logic [3:0] FASE_DIR_FIN = 4'd4;
    localparam logic [3:0] FASE_DAT_INI = 4'd9;
    localparam logic [3:0] FASE_DAT_STB = 4'd10;
    localparam logic [3:0] FASE_ULTIMA  = 4'd14;

    typedef struct packed {
        logic cs_n;
        logic rd_n;
        logic wr_n;
        logic ad;
        logic oe;
    } ctrl_bus_t;

    localparam ctrl_bus_t BUS_INACTIVO = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad: 1'b1, oe: 1'b0};

endpackage

// File: rtl/generador_senales_bus_decodificador_fase.sv
// decodificador_fase: combinational map from the frame phase and transaction
// direction to the bus control pattern for that phase.
//   i_fase      phase index 0..14 (15 decodes to the idle pattern)
//   i_w_r       1 = write transaction, 0 = read
//   o_ctrl      cs_n / rd_n / wr_n / ad / oe for this phase
//   o_sel_dato  1 = pads carry write data, 0 = pads carry the address
module decodificador_fase
    import bus_tiempos_pkg::*;
(
    input  logic [3:0] i_fase,
    input  logic       i_w_r,
    output ctrl_bus_t  o_ctrl,
    output logic       o_sel_dato
);

    logic w_dato_esc;

    // Write data is driven from FASE_DAT_INI through two phases past the strobe
    // so it is stable around the rising edge of wr_n.
    assign w_dato_esc = i_w_r && (i_fase >= FASE_DAT_INI) && (i_fase <= FASE_DAT_STB + 4'd2);

    always_comb begin
        o_ctrl     = BUS_INACTIVO;
        o_sel_dato = 1'b0;

        // ad stays low one phase past the address drive window
        if (i_fase <= FASE_DIR_FIN) o_ctrl.ad = 1'b0;
        if (i_fase < FASE_DIR_FIN)  o_ctrl.oe = 1'b1;

        // the address is always latched by the peripheral with wr_n
        if (i_fase == FASE_DIR_STB) begin
            o_ctrl.cs_n = 1'b0;
            o_ctrl.wr_n = 1'b0;
        end
        if (i_fase == FASE_DIR_STB + 4'd1) o_ctrl.cs_n = 1'b0;

        if (w_dato_esc) begin
            o_ctrl.oe  = 1'b1;
            o_sel_dato = 1'b1;
        end
        if ((i_fase == FASE_DAT_STB) || (i_fase == FASE_DAT_STB + 4'd1)) o_ctrl.cs_n = 1'b0;
        if (i_fase == FASE_DAT_STB) begin
            if (i_w_r) o_ctrl.wr_n = 1'b0;
            else       o_ctrl.rd_n = 1'b0;
        end
    end

endmodule

// File: rtl/generador_senales_bus.sv
// generador_senales_bus: runs one multiplexed address/data bus transaction per
// request, aligned to the frame of the free-running phase counter.
//   clk, reset_n        clock, synchronous active-low reset
//   fase                phase index from the timing counter
//   inicio, w_r         request strobe and direction (1 = write)
//   direccion           address, latched on accepted request
//   dato_escritura      write data, latched on accepted request
//   bus_in              read data from the pads
//   bus_out, bus_oe     data to the pads and its output enable
//   cs_n, rd_n, wr_n    active-low chip select / read / write strobes
//   ad                  0 = address cycle, 1 = data cycle
//   dato_leido          last captured read data
//   ocupado, listo      busy flag, one-cycle end-of-transaction pulse
//
// state        | meaning
// REPOSO       | idle, accepting inicio
// ESPERA_TRAMA | request latched, waiting for the next 14->0 frame boundary
// TRAMA        | bus outputs follow the decoded phase, one cycle behind fase
// FIN          | listo high for one cycle, ocupado drops on the next edge
module generador_senales_bus
    import bus_tiempos_pkg::*;
#(
    parameter int         ANCHO_DATO   = 8,
    parameter logic [3:0] FASE_CAPTURA = 4'd10
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            fase,
    input  logic                  inicio,
    input  logic                  w_r,
    input  logic [ANCHO_DATO-1:0] direccion,
    input  logic [ANCHO_DATO-1:0] dato_escritura,
    input  logic [ANCHO_DATO-1:0] bus_in,
    output logic [ANCHO_DATO-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  cs_n,
    output logic                  rd_n,
    output logic                  wr_n,
    output logic                  ad,
    output logic [ANCHO_DATO-1:0] dato_leido,
    output logic                  ocupado,
    output logic                  listo
);

    estado_t               r_estado;
    logic [3:0]            r_fase_q;
    logic                  r_w_r;
    logic [ANCHO_DATO-1:0] r_dir;
    logic [ANCHO_DATO-1:0] r_dato;

    ctrl_bus_t             w_ctrl;
    logic                  w_sel_dato;
    logic                  w_limite;
    logic                  w_captura;
    logic [ANCHO_DATO-1:0] w_bus_dec;

    decodificador_fase u_decodificador_fase (
        .i_fase     (fase),
        .i_w_r      (r_w_r),
        .o_ctrl     (w_ctrl),
        .o_sel_dato (w_sel_dato)
    );

    assign w_limite  = (r_fase_q == FASE_ULTIMA) && (fase == FASE_DIR_INI);
    assign w_captura = (r_fase_q == FASE_CAPTURA) && (fase == FASE_CAPTURA + 4'd1);
    assign w_bus_dec = w_ctrl.oe ? (w_sel_dato ? r_dato : r_dir) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_estado                        <= REPOSO;
            r_fase_q                        <= 4'd0;
            r_w_r                           <= 1'b0;
            r_dir                           <= '0;
            r_dato                          <= '0;
            {cs_n, rd_n, wr_n, ad, bus_oe}  <= BUS_INACTIVO;
            bus_out                         <= '0;
            dato_leido                      <= '0;
            ocupado                         <= 1'b0;
            listo                           <= 1'b0;
        end else begin
            r_fase_q <= fase;
            listo    <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_w_r    <= w_r;
                        r_dir    <= direccion;
                        r_dato   <= dato_escritura;
                        ocupado  <= 1'b1;
                        r_estado <= ESPERA_TRAMA;
                    end
                end
                ESPERA_TRAMA: begin
                    // load the phase-0 pattern on the boundary edge itself so the
                    // one-cycle lag holds from the very first phase of the frame
                    if (w_limite) begin
                        r_estado                       <= TRAMA;
                        {cs_n, rd_n, wr_n, ad, bus_oe} <= w_ctrl;
                        bus_out                        <= w_bus_dec;
                    end
                end
                TRAMA: begin
                    if (w_limite) begin
                        r_estado                       <= FIN;
                        listo                          <= 1'b1;
                        {cs_n, rd_n, wr_n, ad, bus_oe} <= BUS_INACTIVO;
                        bus_out                        <= '0;
                    end else begin
                        {cs_n, rd_n, wr_n, ad, bus_oe} <= w_ctrl;
                        bus_out                        <= w_bus_dec;
                        if (!r_w_r && w_captura) dato_leido <= bus_in;
                    end
                end
                FIN: begin
                    ocupado  <= 1'b0;
                    r_estado <= REPOSO;
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_generador_senales_bus.sv
// Bench for generador_senales_bus. The whole phase stream and bus_in stream are
// generated up front, so each accepted request can be turned into an expected
// transaction (acceptance edge, frame start, frame end, captured data) and
// pushed into a scoreboard. A monitor compares every cycle against the phase
// table and pops each transaction at its end.
module tb_generador_senales_bus;

    localparam int NARR = 8000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] fase;
    logic       inicio;
    logic       w_r;
    logic [7:0] direccion;
    logic [7:0] dato_escritura;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad;
    logic [7:0] dato_leido;
    logic       ocupado;
    logic       listo;

    always #5 clk = ~clk;

    generador_senales_bus #(
        .ANCHO_DATO   (8),
        .FASE_CAPTURA (4'd10)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fase           (fase),
        .inicio         (inicio),
        .w_r            (w_r),
        .direccion      (direccion),
        .dato_escritura (dato_escritura),
        .bus_in         (bus_in),
        .bus_out        (bus_out),
        .bus_oe         (bus_oe),
        .cs_n           (cs_n),
        .rd_n           (rd_n),
        .wr_n           (wr_n),
        .ad             (ad),
        .dato_leido     (dato_leido),
        .ocupado        (ocupado),
        .listo          (listo)
    );

    typedef struct {
        int         a;
        int         s;
        int         e;
        bit         w;
        logic [7:0] dir;
        logic [7:0] dat;
        logic [7:0] exp_rd;
    } trans_t;

    logic [3:0] fase_arr  [NARR];
    logic [7:0] busin_arr [NARR];
    bit         rst_at    [NARR];
    trans_t     sb[$];

    int         edge_n    = 0;
    int         n_chk     = 0;
    int         n_fail    = 0;
    int         free_edge = 0;
    int         ult_s     = 0;
    logic [7:0] dl_model  = 8'h00;
    bit         forzar_en = 1'b0;
    logic [7:0] forzar_val = 8'h00;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nom, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: edge %0d got %h expected %h", nom, edge_n - 1, act, req);
        end
    endtask

    function automatic bit es_limite(int t);
        return (t > 0) && (t < NARR) && (fase_arr[t-1] == 4'd14) && (fase_arr[t] == 4'd0);
    endfunction

    function automatic int sig_limite(int t);
        for (int i = t + 1; i < NARR; i++) if (es_limite(i)) return i;
        return NARR;
    endfunction

    function automatic int ult_limite(int t);
        for (int i = t; i > 0; i--) if (es_limite(i)) return i;
        return 0;
    endfunction

    // first acceptance edge whose frame contains a fase=15 glitch
    function automatic int objetivo_15(int desde);
        for (int j = desde + 1; j < NARR; j++) begin
            if (fase_arr[j] == 4'd15) begin
                int b;
                int b0;
                b  = ult_limite(j);
                b0 = ult_limite(b - 1);
                if (b0 >= desde && b0 + 1 < b) return b0 + 1;
            end
        end
        return NARR;
    endfunction

    // bus pattern for one phase, straight from the phase table:
    // {cs_n, rd_n, wr_n, ad, oe, data}
    function automatic logic [12:0] tabla(logic [3:0] f, bit w, logic [7:0] dir, logic [7:0] dat);
        int p;
        bit cs, wr, rd, dir_on, dat_on;
        logic [7:0] d;
        p      = int'(f);
        cs     = (p == 1) || (p == 2) || (p == 10) || (p == 11);
        wr     = (p == 1) || (w && p == 10);
        rd     = !w && (p == 10);
        dir_on = (p <= 3);
        dat_on = w && (p >= 9) && (p <= 12);
        d      = dir_on ? dir : (dat_on ? dat : 8'h00);
        return {!cs, !rd, !wr, !(p <= 4), dir_on || dat_on, d};
    endfunction

    task automatic paso(input bit rst_b, input bit ini, input bit wr,
                        input logic [7:0] d, input logic [7:0] x);
        trans_t r;
        @(negedge clk);
        if (edge_n >= NARR - 1) begin
            n_chk++;
            n_fail++;
            $display("FAIL presupuesto: edge %0d got timeout expected completion", edge_n);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
        reset_n        = rst_b;
        inicio         = ini;
        w_r            = wr;
        direccion      = d;
        dato_escritura = x;
        rst_at[edge_n] = !rst_b;
        if (!rst_b) begin
            free_edge = edge_n + 1;
            dl_model  = 8'h00;
        end else if (ini && edge_n >= free_edge) begin
            r.a   = edge_n;
            r.s   = sig_limite(edge_n);
            r.e   = sig_limite(r.s);
            r.w   = wr;
            r.dir = d;
            r.dat = x;
            if (!wr) begin
                for (int t = r.s + 1; t < r.e && t < NARR; t++) begin
                    if (fase_arr[t-1] == 4'd10 && fase_arr[t] == 4'd11) begin
                        if (forzar_en) begin
                            busin_arr[t] = forzar_val;
                            for (int j = t - 1; j > 0 && fase_arr[j] == 4'd10; j--)
                                busin_arr[j] = forzar_val;
                        end
                        dl_model = busin_arr[t];
                    end
                end
            end
            r.exp_rd  = dl_model;
            ult_s     = r.s;
            free_edge = r.e + 2;
            sb.push_back(r);
        end
        fase   = fase_arr[edge_n];
        bus_in = busin_arr[edge_n];
    endtask

    task automatic idle();
        paso(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    endtask

    // wait until the DUT is back in REPOSO; stray requests meanwhile must be ignored
    task automatic hasta_libre(input bit spam);
        while (edge_n < free_edge) begin
            if (spam && $urandom_range(0, 7) == 0)
                paso(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'hFF, 8'($urandom));
            else
                idle();
        end
    endtask

    // per-cycle monitor and scoreboard
    int          mk;
    trans_t      mr;
    logic [12:0] meb;
    bit          mbusy, mlst;
    logic [7:0]  exp_dl = 8'h00;

    always @(negedge clk) begin
        mk = edge_n - 1;
        if (mk >= 0 && mk < NARR) begin
            meb   = {5'b11110, 8'h00};
            mbusy = 1'b0;
            mlst  = 1'b0;
            if (rst_at[mk]) begin
                sb.delete();
                exp_dl = 8'h00;
            end else if (sb.size() > 0) begin
                mr = sb[0];
                if (mk >= mr.a && mk <= mr.e) mbusy = 1'b1;
                if (mk >= mr.s && mk < mr.e) meb = tabla(fase_arr[mk], mr.w, mr.dir, mr.dat);
                if (!mr.w && mk > mr.s && mk < mr.e && fase_arr[mk-1] == 4'd10 && fase_arr[mk] == 4'd11)
                    exp_dl = busin_arr[mk];
                if (mk == mr.e) begin
                    mlst = 1'b1;
                    chk("transaccion", {listo, dato_leido}, {1'b1, mr.exp_rd});
                    void'(sb.pop_front());
                end
            end
            chk("ciclo", {cs_n, rd_n, wr_n, ad, bus_oe, bus_out, ocupado, listo, dato_leido},
                         {meb, mbusy, mlst, exp_dl});
        end
    end

    initial begin
        int idx;
        int f;
        int tgt;

        idx = 0;
        f   = 0;
        while (idx < NARR) begin
            for (int p = (f == 0) ? 5 : 0; p < 15; p++) begin
                int d;
                if (p == 14 && f % 7 == 5) continue;   // frame with no 14->0 boundary
                d = (p == 1 || p == 10) ? int'($urandom_range(3, 11)) : int'($urandom_range(2, 7));
                if (p == 2 && f % 3 == 2) d = int'($urandom_range(4, 7));
                for (int i = 0; i < d && idx < NARR; i++) begin
                    fase_arr[idx]  = (p == 2 && f % 3 == 2 && i < 2) ? 4'd15 : 4'(p);
                    busin_arr[idx] = 8'($urandom);
                    idx++;
                end
            end
            f++;
        end

        reset_n        = 1'b0;
        inicio         = 1'b0;
        w_r            = 1'b0;
        direccion      = 8'h00;
        dato_escritura = 8'h00;
        fase           = fase_arr[0];
        bus_in         = busin_arr[0];
        rst_at[0]      = 1'b1;
        free_edge      = 1;
        paso(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        paso(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk("reset", {cs_n, rd_n, wr_n, ad, bus_oe, bus_out, dato_leido, ocupado, listo},
                     {5'b11110, 8'h00, 8'h00, 1'b0, 1'b0});

        // write at fase 7, then a stray FF request while busy
        idle();
        while (fase_arr[edge_n] != 4'd7) idle();
        paso(1'b1, 1'b1, 1'b1, 8'h21, 8'h5A);
        repeat (3) idle();
        paso(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00);
        hasta_libre(1'b1);

        // read returning C3, then a write that must leave dato_leido alone
        forzar_en  = 1'b1;
        forzar_val = 8'hC3;
        paso(1'b1, 1'b1, 1'b0, 8'h05, 8'h00);
        forzar_en  = 1'b0;
        hasta_libre(1'b0);
        @(posedge clk); #1;
        chk("lectura_c3", dato_leido, 8'hC3);
        paso(1'b1, 1'b1, 1'b1, 8'h3C, 8'h96);
        hasta_libre(1'b1);
        @(posedge clk); #1;
        chk("lectura_retenida", dato_leido, 8'hC3);

        // request on the boundary edge itself waits a whole frame
        while (!es_limite(edge_n)) idle();
        paso(1'b1, 1'b1, 1'b1, 8'hA5, 8'h77);
        hasta_libre(1'b0);

        // frame containing fase=15
        tgt = objetivo_15(edge_n);
        while (edge_n < tgt) idle();
        paso(1'b1, 1'b1, 1'b1, 8'h4B, 8'hE1);
        hasta_libre(1'b0);
        tgt = objetivo_15(edge_n);
        while (edge_n < tgt) idle();
        paso(1'b1, 1'b1, 1'b0, 8'h12, 8'h00);
        hasta_libre(1'b0);

        // reset while a write is strobing data
        paso(1'b1, 1'b1, 1'b1, 8'h66, 8'h99);
        while (!(edge_n > ult_s && fase_arr[edge_n] == 4'd10)) idle();
        paso(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk("reset_medio", {cs_n, wr_n, bus_oe, ocupado}, {1'b1, 1'b1, 1'b0, 1'b0});
        paso(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        paso(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        repeat (200) idle();

        // random traffic
        for (int n = 0; n < 12; n++) begin
            int gap;
            gap = int'($urandom_range(0, 40));
            for (int g = 0; g < gap; g++) idle();
            if ($urandom_range(0, 3) == 0) while (!es_limite(edge_n)) idle();
            paso(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            hasta_libre(1'b1);
        end
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
